wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter directly upstream of the register file write port; owns `rsd_addr`/`write_data`/`enable`.
- Merges three result sources into one write per cycle:
  - ALU, single-cycle, cannot be stalled.
  - Load unit, valid/ready.
  - Multiplier, valid/ready.
- Buffers each handshaked source in a small FIFO and exports a pending-destination mask for the hazard unit.

Parameters:
- `REG_BITS`, 5, register address width.
- `REG_NUM`, 32, architectural register count.
- `FIFO_DEPTH`, 2, entries per handshaked-source FIFO; power of two, ≥2.
- Data width is `REG_LEN` from `brisc_pkg`, not a parameter.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `alu_valid` input 1: ALU result present this cycle.
- `alu_rd` input `REG_BITS`: ALU destination.
- `alu_data` input `REG_LEN`: ALU result.
- `ld_valid` input 1: load result offered.
- `ld_ready` output 1: load FIFO can accept.
- `ld_rd` input `REG_BITS`: load destination.
- `ld_data` input `REG_LEN`: load result.
- `mul_valid` input 1: multiply result offered.
- `mul_ready` output 1: mul FIFO can accept.
- `mul_rd` input `REG_BITS`: multiply destination.
- `mul_data` input `REG_LEN`: multiply result.
- `wb_enable` output 1: register file write enable.
- `wb_addr` output `REG_BITS`: to register file `rsd_addr`.
- `wb_data` output `REG_LEN`: to register file `write_data`.
- `pending_mask` output `REG_NUM`: bit i set while a write to xi is buffered or in the output register.
- `stall_req` output 1: front-end stall request.

Behaviour:
- **Reset** (`reset`=0, async):
  - Both FIFOs empty; RR pointer = LD.
  - `wb_enable`=0, `wb_addr`=0, `wb_data`=0.
  - `pending_mask`=0, `stall_req`=0, `ld_ready`=`mul_ready`=1 after release.
  - Reset mid-operation discards all buffered results; no partial write.
- **Handshake:**
  - Transfer occurs when valid && ready at the rising edge.
  - `ready` = FIFO count < `FIFO_DEPTH`, from registered count only. No same-cycle dequeue credit.
  - Producers hold rd/data stable while valid && !ready.
- **x0 filtering:**
  - Handshaked entries with rd=0 are accepted (ready honoured) but not stored.
  - ALU with rd=0 is treated as `alu_valid`=0.
- **Arbitration:** one grant per cycle, evaluated combinationally, result registered.
  - ALU valid with rd≠0 always wins.
  - Otherwise the non-empty FIFO is granted. If both are non-empty, the one named by the RR pointer is granted.
  - The RR pointer flips to the other FIFO after each FIFO grant; unchanged on ALU grant or idle.
- **Latency:**
  - Granted entry appears on `wb_*` exactly 1 cycle after grant (registered). Register file writes it on the following edge.
  - ALU: `alu_valid` in cycle N → `wb_enable`=1 in cycle N+1.
  - FIFO: enqueue in cycle N → earliest `wb_enable` in cycle N+2. No bypass around the FIFO.
  - `wb_enable`=0 when no grant; `wb_addr`/`wb_data` hold previous values.
- **Ordering:**
  - FIFO order preserved within one source.
  - No ordering across sources; WAW across sources is prevented upstream using `pending_mask`.
- **`pending_mask`:**
  - Registered OR of one-hot(rd) over all valid FIFO entries and the `wb_*` register when `wb_enable`=1.
  - Recomputed each cycle from next state, so it reflects accepted entries one cycle after the handshake.
  - Duplicate rd in the FIFOs keeps the bit set until the last one retires.
  - Bit 0 is always 0.
- **`stall_req`:**
  - Combinational: either FIFO count ≥ `FIFO_DEPTH`-1 while `alu_valid`=1.
  - Covers the case where the ALU would hold off draining and a producer would be blocked indefinitely.
  - Simultaneous full FIFOs plus continuous ALU traffic: the FIFOs do not drain until the ALU idles. The front end must honour the stall.
- **Simultaneous enqueue and dequeue on the same FIFO:** count unchanged, pointers both advance. Wrap-around uses modulo-`FIFO_DEPTH` pointers.

Decomposition:
- `brisc_pkg` gains:
  - `wb_entry_t` struct {rd, data}.
  - `wb_src_e` enum {`WB_ALU`, `WB_LD`, `WB_MUL`, `WB_NONE`}.
  - `WB_FIFO_DEPTH` constant.
- Sub-module `wb_fifo`: parameterised depth, synchronous FIFO of `wb_entry_t` with count, valid/ready in, pop/empty out, per-entry valid vector for mask generation. Instantiated twice.

Test Plan:
- **Reset:** assert `reset`=0 mid-stream with both FIFOs holding entries → all outputs 0 immediately; after release, `ld_ready`=`mul_ready`=1 and no write ever appears.
- **ALU latency:** `alu_valid`=1, rd=5, data=0xDEADBEEF in cycle 3 → `wb_enable`=1, `wb_addr`=5, `wb_data`=0xDEADBEEF in cycle 4 only.
- **x0 drop:** ALU rd=0 with a load rd=7 data=0x11 queued → load writes in that cycle's grant, nothing is written to x0, `pending_mask`[0]=0 throughout.
- **Round-robin:**
  - Setup: load {3,0xA} and mul {4,0xB} enqueued in the same cycle, ALU idle.
  - Response: writes rd=3 then rd=4 on consecutive cycles; next simultaneous pair writes mul first.
- **Backpressure and stall:**
  - Setup: continuous `alu_valid`, four back-to-back load offers.
  - Response: `ld_ready` drops after 2 accepts; `stall_req`=1 once count ≥1 with `alu_valid`; loads drain in order after ALU idles.
- **Pending mask:** load rd=9 accepted cycle N → `pending_mask`[9]=1 from N+1 until the cycle after its `wb_enable`; a second in-flight rd=9 keeps the bit set until the last retires.

Source files
------------

// File: rtl/brisc_pkg.sv
// rtl/brisc_pkg.sv - shared core types and constants for the writeback path
package brisc_pkg;

    localparam int REG_LEN       = 32;
    localparam int WB_REG_BITS   = 5;
    localparam int WB_REG_NUM    = 32;
    localparam int WB_FIFO_DEPTH = 2;

    // One buffered writeback: destination register and the value to write.
    typedef struct packed {
        logic [WB_REG_BITS-1:0] rd;
        logic [REG_LEN-1:0]     data;
    } wb_entry_t;

    // Which producer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LD   = 2'd1,
        WB_MUL  = 2'd2,
        WB_NONE = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - producer, register-file and hazard-unit signals of the writeback arbiter
interface wb_arbiter_if
    import brisc_pkg::*;
#(
    parameter int REG_BITS = WB_REG_BITS,
    parameter int REG_NUM  = WB_REG_NUM
) ();

    logic                alu_valid;
    logic [REG_BITS-1:0] alu_rd;
    logic [REG_LEN-1:0]  alu_data;

    logic                ld_valid;
    logic                ld_ready;
    logic [REG_BITS-1:0] ld_rd;
    logic [REG_LEN-1:0]  ld_data;

    logic                mul_valid;
    logic                mul_ready;
    logic [REG_BITS-1:0] mul_rd;
    logic [REG_LEN-1:0]  mul_data;

    logic                wb_enable;
    logic [REG_BITS-1:0] wb_addr;
    logic [REG_LEN-1:0]  wb_data;

    logic [REG_NUM-1:0]  pending_mask;
    logic                stall_req;

    // The arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  mul_valid, mul_rd, mul_data,
        output ld_ready, mul_ready,
        output wb_enable, wb_addr, wb_data,
        output pending_mask, stall_req
    );

    // The producers / register file / hazard unit side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output mul_valid, mul_rd, mul_data,
        input  ld_ready, mul_ready,
        input  wb_enable, wb_addr, wb_data,
        input  pending_mask, stall_req
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// rtl/wb_arbiter_fifo.sv - small synchronous FIFO of writeback entries with next-state occupancy export
module wb_fifo
    import brisc_pkg::*;
#(
    parameter  int DEPTH = WB_FIFO_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  wb_entry_t        in_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [DEPTH-1:0] valid_d_o,
    output wb_entry_t        mem_d_o [DEPTH]
);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic             push;
    logic             pop;

    // Ready looks only at the registered count: a pop this cycle does not free a slot early.
    assign in_ready_o = (count_q < CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    // Writes to x0 complete the handshake but are never stored.
    assign push       = in_valid_i && in_ready_o && (in_entry_i.rd != '0);
    assign pop        = pop_i && !empty_o;
    assign head_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign valid_d_o  = valid_d;
    assign mem_d_o    = mem_d;

    // Next-state: retire the head and/or append at the tail; pointers wrap modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q]   = in_entry_i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Storage, pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU, load and multiply results into one register-file write per cycle
module wb_arbiter
    import brisc_pkg::*;
#(
    parameter int REG_BITS   = WB_REG_BITS,
    parameter int REG_NUM    = WB_REG_NUM,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);

    localparam int             CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  STALL_LEVEL = CW'(FIFO_DEPTH - 1);

    wb_entry_t             ld_in, mul_in;
    wb_entry_t             ld_head, mul_head;
    logic                  ld_empty, mul_empty;
    logic                  ld_pop, mul_pop;
    logic [CW-1:0]         ld_count, mul_count;
    logic [FIFO_DEPTH-1:0] ld_valid_d, mul_valid_d;
    wb_entry_t             ld_mem_d  [FIFO_DEPTH];
    wb_entry_t             mul_mem_d [FIFO_DEPTH];

    wb_src_e               grant;
    logic                  alu_hit;
    logic                  rr_mul_q, rr_mul_d;
    logic                  wb_en_q, wb_en_d;
    logic [REG_BITS-1:0]   wb_addr_q, wb_addr_d;
    logic [REG_LEN-1:0]    wb_data_q, wb_data_d;
    logic [REG_NUM-1:0]    mask_q, mask_d;

    assign ld_in   = '{rd: bus.ld_rd,  data: bus.ld_data};
    assign mul_in  = '{rd: bus.mul_rd, data: bus.mul_data};
    // An ALU result aimed at x0 is indistinguishable from no result.
    assign alu_hit = bus.alu_valid && (bus.alu_rd != '0);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_ld_fifo (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (bus.ld_valid),
        .in_ready_o (bus.ld_ready),
        .in_entry_i (ld_in),
        .pop_i      (ld_pop),
        .head_o     (ld_head),
        .empty_o    (ld_empty),
        .count_o    (ld_count),
        .valid_d_o  (ld_valid_d),
        .mem_d_o    (ld_mem_d)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mul_fifo (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (bus.mul_valid),
        .in_ready_o (bus.mul_ready),
        .in_entry_i (mul_in),
        .pop_i      (mul_pop),
        .head_o     (mul_head),
        .empty_o    (mul_empty),
        .count_o    (mul_count),
        .valid_d_o  (mul_valid_d),
        .mem_d_o    (mul_mem_d)
    );

    // Grant selection: the unstallable ALU first, then the FIFOs, sharing by round-robin when both wait.
    always_comb begin
        grant    = WB_NONE;
        rr_mul_d = rr_mul_q;
        if (alu_hit) begin
            grant = WB_ALU;
        end else if (!ld_empty && !mul_empty) begin
            grant = rr_mul_q ? WB_MUL : WB_LD;
        end else if (!ld_empty) begin
            grant = WB_LD;
        end else if (!mul_empty) begin
            grant = WB_MUL;
        end
        if (grant == WB_LD) begin
            rr_mul_d = 1'b1;
        end else if (grant == WB_MUL) begin
            rr_mul_d = 1'b0;
        end
    end

    assign ld_pop  = (grant == WB_LD);
    assign mul_pop = (grant == WB_MUL);

    // Next write-port contents; address and data hold when nothing is granted.
    always_comb begin
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (grant)
            WB_ALU: begin
                wb_en_d   = 1'b1;
                wb_addr_d = bus.alu_rd;
                wb_data_d = bus.alu_data;
            end
            WB_LD: begin
                wb_en_d   = 1'b1;
                wb_addr_d = ld_head.rd;
                wb_data_d = ld_head.data;
            end
            WB_MUL: begin
                wb_en_d   = 1'b1;
                wb_addr_d = mul_head.rd;
                wb_data_d = mul_head.data;
            end
            default: ;
        endcase
    end

    // Destinations still owed a write, taken from next-state so the mask lines up with the registers.
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ld_valid_d[i]) begin
                mask_d[ld_mem_d[i].rd] = 1'b1;
            end
            if (mul_valid_d[i]) begin
                mask_d[mul_mem_d[i].rd] = 1'b1;
            end
        end
        if (wb_en_d) begin
            mask_d[wb_addr_d] = 1'b1;
        end
        mask_d[0] = 1'b0;
    end

    // Write-port register, round-robin pointer and pending mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_mul_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            mask_q    <= '0;
        end else begin
            rr_mul_q  <= rr_mul_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            mask_q    <= mask_d;
        end
    end

    assign bus.wb_enable    = wb_en_q;
    assign bus.wb_addr      = wb_addr_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.pending_mask = mask_q;
    // A nearly full FIFO cannot be drained while the ALU keeps the port busy, so hold the front end.
    assign bus.stall_req    = bus.alu_valid &&
                              ((ld_count >= STALL_LEVEL) || (mul_count >= STALL_LEVEL));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    import brisc_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.REG_BITS(5), .REG_NUM(32)) bus ();

    wb_arbiter #(.REG_BITS(5), .REG_NUM(32), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
        bus.mul_valid = 1'b0; bus.mul_rd = '0; bus.mul_data = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        cyc();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data, bus.pending_mask, bus.stall_req} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b addr=%h data=%h mask=%h stall=%b want all 0",
                     bus.wb_enable, bus.wb_addr, bus.wb_data, bus.pending_mask, bus.stall_req);
        end
        reset = 1'b1;
        sample();
        total++;
        if ({bus.ld_ready, bus.mul_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready got=%b want=11", {bus.ld_ready, bus.mul_ready});
        end
    endtask

    task automatic test_alu_latency();
        cyc();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        sample();
        total++;
        if (bus.wb_enable !== 1'b0) begin
            bad++;
            $display("FAIL alu_same_cycle got en=%b want=0", bus.wb_enable);
        end
        cyc();
        idle();
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL alu_next_cycle got en=%b addr=%0d data=%h want en=1 addr=5 data=deadbeef",
                     bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
        total++;
        if (bus.pending_mask !== 32'h0000_0020) begin
            bad++;
            $display("FAIL alu_mask got=%h want=00000020", bus.pending_mask);
        end
        cyc();
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data, bus.pending_mask} !== {1'b0, 5'd5, 32'hDEADBEEF, 32'h0}) begin
            bad++;
            $display("FAIL alu_one_shot got en=%b addr=%0d data=%h mask=%h want en=0 addr=5 data=deadbeef mask=0",
                     bus.wb_enable, bus.wb_addr, bus.wb_data, bus.pending_mask);
        end
    endtask

    task automatic test_x0();
        cyc();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h11;
        sample();
        total++;
        if (bus.ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL x0_ld_ready got=%b want=1", bus.ld_ready);
        end
        cyc();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
        sample();
        total++;
        if (bus.stall_req !== 1'b1) begin
            bad++;
            $display("FAIL x0_stall got=%b want=1", bus.stall_req);
        end
        total++;
        if (bus.pending_mask !== 32'h0000_0080) begin
            bad++;
            $display("FAIL x0_mask_queued got=%h want=00000080", bus.pending_mask);
        end
        cyc();
        idle();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h99;
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data, bus.pending_mask} !== {1'b1, 5'd7, 32'h11, 32'h80}) begin
            bad++;
            $display("FAIL x0_load_write got en=%b addr=%0d data=%h mask=%h want en=1 addr=7 data=11 mask=80",
                     bus.wb_enable, bus.wb_addr, bus.wb_data, bus.pending_mask);
        end
        total++;
        if (bus.ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL x0_zero_rd_ready got=%b want=1", bus.ld_ready);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            idle();
            sample();
            total++;
            if ({bus.wb_enable, bus.pending_mask} !== {1'b0, 32'h0}) begin
                bad++;
                $display("FAIL x0_no_write[%0d] got en=%b mask=%h want en=0 mask=0", k, bus.wb_enable, bus.pending_mask);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd3; bus.ld_data  = 32'hA;
        bus.mul_valid = 1'b1; bus.mul_rd = 5'd4; bus.mul_data = 32'hB;
        sample();
        cyc();
        idle();
        sample();
        total++;
        if (bus.wb_enable !== 1'b0) begin
            bad++;
            $display("FAIL rr_no_bypass got en=%b want=0", bus.wb_enable);
        end
        cyc();
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd3, 32'hA}) begin
            bad++;
            $display("FAIL rr_first got en=%b addr=%0d data=%h want en=1 addr=3 data=a", bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
        cyc();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd8; bus.ld_data = 32'hE;
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd4, 32'hB}) begin
            bad++;
            $display("FAIL rr_second got en=%b addr=%0d data=%h want en=1 addr=4 data=b", bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
        cyc();
        idle();
        sample();
        cyc();
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd5; bus.ld_data  = 32'hC;
        bus.mul_valid = 1'b1; bus.mul_rd = 5'd6; bus.mul_data = 32'hD;
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd8, 32'hE}) begin
            bad++;
            $display("FAIL rr_lone_load got en=%b addr=%0d data=%h want en=1 addr=8 data=e", bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
        cyc();
        idle();
        sample();
        cyc();
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd6, 32'hD}) begin
            bad++;
            $display("FAIL rr_mul_first got en=%b addr=%0d data=%h want en=1 addr=6 data=d", bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
        cyc();
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd5, 32'hC}) begin
            bad++;
            $display("FAIL rr_ld_second got en=%b addr=%0d data=%h want en=1 addr=5 data=c", bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] wq[$];
        logic [36:0] exp_e;
        int          idx = 0;
        logic        acc;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            bus.alu_valid = (c < 4);
            bus.alu_rd    = 5'd1;
            bus.alu_data  = 32'(c);
            bus.ld_valid  = (idx < 4);
            bus.ld_rd     = 5'(10 + idx);
            bus.ld_data   = 32'(32'h100 + idx);
            sample();
            if (c < 5) begin
                total++;
                if ({bus.ld_ready, bus.stall_req} !== {(c < 2), (c >= 1 && c <= 3)}) begin
                    bad++;
                    $display("FAIL bp_ready_stall[c%0d] got ready=%b stall=%b want ready=%b stall=%b",
                             c, bus.ld_ready, bus.stall_req, (c < 2), (c >= 1 && c <= 3));
                end
            end
            if (bus.wb_enable && bus.wb_addr != 5'd1) wq.push_back({bus.wb_addr, bus.wb_data});
            acc = bus.ld_valid && bus.ld_ready;
            cyc();
            if (acc) idx++;
        end
        idle();
        total++;
        if (idx !== 4 || wq.size() !== 4) begin
            bad++;
            $display("FAIL bp_counts got accepted=%0d written=%0d want 4 and 4", idx, wq.size());
        end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            exp_e = {5'(10 + i), 32'(32'h100 + i)};
            total++;
            if (wq[i] !== exp_e) begin
                bad++;
                $display("FAIL bp_order[%0d] got=%h want=%h", i, wq[i], exp_e);
            end
        end
    endtask

    task automatic test_pending_mask();
        do_reset();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h9;
        sample();
        total++;
        if (bus.pending_mask[9] !== 1'b0) begin
            bad++;
            $display("FAIL pm_before got=%b want=0", bus.pending_mask[9]);
        end
        cyc();
        idle();
        sample();
        total++;
        if (bus.pending_mask !== 32'h0000_0200) begin
            bad++;
            $display("FAIL pm_queued got=%h want=00000200", bus.pending_mask);
        end
        cyc();
        sample();
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.pending_mask[9]} !== {1'b1, 5'd9, 1'b1}) begin
            bad++;
            $display("FAIL pm_writing got en=%b addr=%0d bit9=%b want en=1 addr=9 bit9=1", bus.wb_enable, bus.wb_addr, bus.pending_mask[9]);
        end
        cyc();
        sample();
        total++;
        if (bus.pending_mask !== 32'h0) begin
            bad++;
            $display("FAIL pm_retired got=%h want=0", bus.pending_mask);
        end
        cyc();
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd9; bus.ld_data  = 32'h1;
        bus.mul_valid = 1'b1; bus.mul_rd = 5'd9; bus.mul_data = 32'h2;
        sample();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            idle();
            sample();
            total++;
            if ({bus.wb_enable, bus.pending_mask} !== {(k >= 2 && k <= 3), (k <= 3) ? 32'h200 : 32'h0}) begin
                bad++;
                $display("FAIL pm_dup[M+%0d] got en=%b mask=%h want en=%b mask=%h", k, bus.wb_enable, bus.pending_mask,
                         (k >= 2 && k <= 3), (k <= 3) ? 32'h200 : 32'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h55;
            bus.ld_valid  = 1'b1; bus.ld_rd  = 5'(20 + k); bus.ld_data  = 32'(k);
            bus.mul_valid = 1'b1; bus.mul_rd = 5'(22 + k); bus.mul_data = 32'(k);
            sample();
            cyc();
        end
        bus.ld_valid  = 1'b0;
        bus.mul_valid = 1'b0;
        #1;
        total++;
        if ({bus.ld_ready, bus.mul_ready, bus.stall_req} !== 3'b001) begin
            bad++;
            $display("FAIL mid_full got ready=%b%b stall=%b want ready=00 stall=1", bus.ld_ready, bus.mul_ready, bus.stall_req);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({bus.wb_enable, bus.wb_addr, bus.wb_data, bus.pending_mask, bus.stall_req} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got en=%b addr=%h data=%h mask=%h stall=%b want all 0",
                     bus.wb_enable, bus.wb_addr, bus.wb_data, bus.pending_mask, bus.stall_req);
        end
        idle();
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample();
            total++;
            if ({bus.wb_enable, bus.ld_ready, bus.mul_ready, bus.pending_mask} !== {3'b011, 32'h0}) begin
                bad++;
                $display("FAIL mid_after[%0d] got en=%b ready=%b%b mask=%h want en=0 ready=11 mask=0",
                         k, bus.wb_enable, bus.ld_ready, bus.mul_ready, bus.pending_mask);
            end
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_alu_latency();
        test_x0();
        test_round_robin();
        test_backpressure();
        test_pending_mask();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
